// File: rtl/kernel_mcu_pio_irq_dispatcher.sv
// -----------------------------------------------------------------------------
// kernel_mcu_pio_irq_dispatcher
//
// Avalon-MM master that owns the MCU PIO slave. It turns the PIO level
// interrupt into a stream of line-index events:
//   - reads the PIO input register when pio_irq is high,
//   - round-robin arbitrates among the pending (unmasked) lines,
//   - masks the granted line in the PIO and queues its index in a small FIFO,
//   - re-enables a line in the PIO once the consumer pops its event.
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   pio_irq         PIO level interrupt, |(in & mask)
//   pio_address     PIO register select (0 = input data, 2 = IRQ mask)
//   pio_chipselect  one-cycle strobe per mask write
//   pio_write_n     active-low write strobe
//   pio_writedata   mask value in [NLINES-1:0], upper bits zero
//   pio_readdata    PIO read data, one cycle after pio_address
//   evt_valid       event FIFO non-empty
//   evt_line        line index at the FIFO head (0 when empty)
//   evt_ready       consumer pop, taken when evt_valid & evt_ready
// -----------------------------------------------------------------------------
module kernel_mcu_pio_irq_dispatcher #(
    parameter int          NLINES     = 7,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [6:0]  INIT_MASK  = 7'h7F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pio_irq,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    output logic        evt_valid,
    output logic [2:0]  evt_line,
    input  logic        evt_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_REQ,
        S_RD_CAP,
        S_ARB,
        S_MASK_WR,
        S_UNMASK_WR
    } state_t;

    state_t state;
    state_t next_state;

    // started stays low while reset is held so INIT's write is not driven
    // onto the bus during reset; INIT then writes in the first clocked cycle.
    logic              started;
    logic [NLINES-1:0] mask_sh;
    logic [NLINES-1:0] unmask_pend;
    logic [2:0]        rr_ptr;
    logic [NLINES-1:0] pend;
    logic [2:0]        grant_q;
    logic [2:0]        grant_c;

    logic [2:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [NLINES-1:0] pop_bits;

    logic              wr_en;
    logic [NLINES-1:0] wr_val;

    logic              unused_readdata;
    assign unused_readdata = ^pio_readdata[31:NLINES];

    // One-hot bit for a line index; indices outside the line range map to 0.
    function automatic logic [NLINES-1:0] line_bit(input logic [2:0] l);
        logic [NLINES-1:0] r;
        for (int i = 0; i < NLINES; i++) begin
            r[i] = (l == i[2:0]);
        end
        return r;
    endfunction

    // Round-robin pick: first set bit strictly after 'last', wrapping from
    // the top line back to line 0; 'last' itself is reached only at the end.
    function automatic logic [2:0] rr_pick(input logic [NLINES-1:0] req,
                                           input logic [2:0]        last);
        logic [2:0] r;
        logic       found;
        int         idx;
        r     = last;
        found = 1'b0;
        for (int k = 1; k <= NLINES; k++) begin
            idx = (int'(last) + k) % NLINES;
            if (!found && req[idx]) begin
                r     = idx[2:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign grant_c   = rr_pick(pend, rr_ptr);
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign evt_valid = (count != '0);
    assign evt_line  = evt_valid ? fifo_mem[rd_ptr] : 3'd0;
    assign pop       = evt_valid & evt_ready;
    assign push      = (state == S_MASK_WR);
    assign pop_bits  = pop ? line_bit(evt_line) : '0;

    // Next-state and bus decode
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_val     = '0;
        case (state)
            S_INIT: begin
                if (started) begin
                    wr_en      = 1'b1;
                    wr_val     = INIT_MASK[NLINES-1:0];
                    next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                // Re-enabling popped lines takes precedence over new reads.
                if (unmask_pend != '0) begin
                    next_state = S_UNMASK_WR;
                end else if (pio_irq && !fifo_full) begin
                    next_state = S_RD_REQ;
                end
            end
            S_RD_REQ:  next_state = S_RD_CAP;
            S_RD_CAP:  next_state = S_ARB;
            S_ARB: begin
                // Input dropped before capture: nothing to service.
                next_state = (pend != '0) ? S_MASK_WR : S_IDLE;
            end
            S_MASK_WR: begin
                wr_en      = 1'b1;
                wr_val     = mask_sh & ~line_bit(grant_q);
                next_state = S_IDLE;
            end
            S_UNMASK_WR: begin
                wr_en      = 1'b1;
                wr_val     = mask_sh | unmask_pend;
                next_state = S_IDLE;
            end
            default:   next_state = S_INIT;
        endcase
    end

    assign pio_chipselect = wr_en;
    assign pio_write_n    = ~wr_en;
    assign pio_address    = wr_en ? 2'd2 : 2'd0;
    assign pio_writedata  = wr_en ? {{(32-NLINES){1'b0}}, wr_val} : 32'd0;

    // Control state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_INIT;
            started     <= 1'b0;
            mask_sh     <= '0;
            unmask_pend <= '0;
            rr_ptr      <= 3'(NLINES - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state   <= next_state;
            started <= 1'b1;

            if (wr_en) begin
                mask_sh <= wr_val;
            end

            // Every pending bit is written out in UNMASK_WR, so only bits
            // popped in that same cycle remain pending afterwards.
            if (state == S_UNMASK_WR) begin
                unmask_pend <= pop_bits;
            end else begin
                unmask_pend <= unmask_pend | pop_bits;
            end

            if (state == S_ARB && pend != '0) begin
                rr_ptr <= grant_c;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (state == S_RD_CAP) begin
            pend <= pio_readdata[NLINES-1:0] & mask_sh;
        end
        if (state == S_ARB) begin
            grant_q <= grant_c;
        end
        if (push) begin
            fifo_mem[wr_ptr] <= grant_q;
        end
    end

endmodule

// File: tb/tb_kernel_mcu_pio_irq_dispatcher.sv
module tb_kernel_mcu_pio_irq_dispatcher;

    logic        clk;
    logic        reset_n;
    logic        pio_irq;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        evt_valid;
    logic [2:0]  evt_line;
    logic        evt_ready;

    logic [6:0]  in_port;
    logic [6:0]  pio_mask;

    int          checks;
    int          errors;
    int          exp_q[$];
    logic [31:0] wr_log[$];
    logic        cs_prev;

    kernel_mcu_pio_irq_dispatcher dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pio_irq        (pio_irq),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .evt_valid      (evt_valid),
        .evt_line       (evt_line),
        .evt_ready      (evt_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave model: input register at 0, IRQ mask at 2, registered readdata.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_mask     <= 7'h00;
            pio_readdata <= 32'd0;
        end else begin
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
                pio_mask <= pio_writedata[6:0];
            pio_readdata <= (pio_address == 2'd2) ? {25'd0, pio_mask} : {25'd0, in_port};
        end
    end
    assign pio_irq = |(in_port & pio_mask);

    // Bus write log and shape check (address 2, upper bits zero, one cycle).
    always @(posedge clk) begin
        if (reset_n && pio_chipselect && !pio_write_n) begin
            wr_log.push_back(pio_writedata);
            checks++;
            if (pio_address !== 2'd2 || pio_writedata[31:7] !== 25'd0 || cs_prev) begin
                errors++;
                $display("FAIL bus_write_shape: addr=%0d data=%h back_to_back=%0b, required addr=2, upper bits 0, not back to back",
                         pio_address, pio_writedata, cs_prev);
            end
        end
        cs_prev = reset_n && pio_chipselect;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: wait for an event, compare with queue head, pop it.
    task automatic consume_event(input string tag);
        int w;
        int expv;
        w = 0;
        while (!evt_valid && w < 60) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!evt_valid) begin
            errors++;
            $display("FAIL %s_timeout: evt_valid=0 after %0d cycles, required 1", tag, w);
        end else begin
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            if (int'(evt_line) !== expv) begin
                errors++;
                $display("FAIL %s_line: evt_line=%0d, required %0d", tag, evt_line, expv);
            end
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        evt_ready = 1'b0;
        in_port   = 7'h00;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h7F) begin
            errors++;
            $display("FAIL reinit_write: cs=%0b data=%h, required cs=1 data=0000007f", pio_chipselect, pio_writedata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        int cs_seen;
        reset_n   = 1'b0;
        evt_ready = 1'b0;
        in_port   = 7'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_address !== 2'd0 ||
            pio_writedata !== 32'd0 || evt_valid !== 1'b0 || evt_line !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: cs=%0b wn=%0b addr=%0d wd=%h v=%0b line=%0d, required 0,1,0,0,0,0",
                     pio_chipselect, pio_write_n, pio_address, pio_writedata, evt_valid, evt_line);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_address !== 2'd2 || pio_writedata !== 32'h7F) begin
            errors++;
            $display("FAIL init_write: cs=%0b wn=%0b addr=%0d wd=%h, required 1,0,2,0000007f",
                     pio_chipselect, pio_write_n, pio_address, pio_writedata);
        end
        @(negedge clk);
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_done: cs=%0b wn=%0b v=%0b, required 0,1,0", pio_chipselect, pio_write_n, evt_valid);
        end
        n = wr_log.size();
        cs_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (pio_chipselect) cs_seen++;
        end
        checks++;
        if (cs_seen != 0 || wr_log.size() != n) begin
            errors++;
            $display("FAIL idle_quiet: %0d chipselect cycles, required 0", cs_seen);
        end
    endtask

    task automatic test_single_line();
        int n;
        n = wr_log.size();
        exp_q.push_back(2);
        in_port = 7'b0000100;
        repeat (4) @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: evt_valid=%0b after 4th edge is due, required 0 before edge 4", evt_valid);
        end
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_line !== 3'd2) begin
            errors++;
            $display("FAIL single_latency: v=%0b line=%0d after edge 4, required v=1 line=2", evt_valid, evt_line);
        end
        checks++;
        if (wr_log.size() != n + 1 || wr_log[wr_log.size()-1] !== 32'h7B) begin
            errors++;
            $display("FAIL single_mask: writes=%0d last=%h, required 1 write of 0000007b", wr_log.size() - n,
                     (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : 32'hx);
        end
        checks++;
        if (pio_irq !== 1'b0) begin
            errors++;
            $display("FAIL single_irq_fall: pio_irq=%0b, required 0", pio_irq);
        end
        in_port = 7'h00;
        consume_event("single");
        repeat (6) @(negedge clk);
        checks++;
        if (wr_log[wr_log.size()-1] !== 32'h7F) begin
            errors++;
            $display("FAIL single_unmask: last write=%h, required 0000007f", wr_log[wr_log.size()-1]);
        end
    endtask

    task automatic test_round_robin();
        int seq[8];
        seq = '{0, 1, 2, 3, 4, 5, 6, 0};
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(seq[i]);
        in_port = 7'h7F;
        for (int i = 0; i < 8; i++) consume_event("rr");
        in_port = 7'h00;
        for (int i = 0; i < 12; i++) begin
            if (evt_valid) begin
                evt_ready = 1'b1;
                @(negedge clk);
                evt_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (wr_log[wr_log.size()-1] !== 32'h7F || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_restore: last write=%h v=%0b, required 0000007f v=0", wr_log[wr_log.size()-1], evt_valid);
        end
    endtask

    task automatic test_fifo_full();
        int n;
        do_reset();
        n = wr_log.size();
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        exp_q.push_back(4);
        in_port = 7'h0F;
        repeat (30) @(negedge clk);
        checks++;
        if (wr_log.size() != n + 4 || wr_log[wr_log.size()-1] !== 32'h70 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_fill: writes=%0d last=%h v=%0b, required 4 writes, last 00000070, v=1",
                     wr_log.size() - n, wr_log[wr_log.size()-1], evt_valid);
        end
        in_port = 7'h1F;
        n = wr_log.size();
        repeat (15) @(negedge clk);
        checks++;
        if (wr_log.size() != n || evt_line !== 3'd0) begin
            errors++;
            $display("FAIL full_hold: writes=%0d head=%0d, required 0 writes head=0", wr_log.size() - n, evt_line);
        end
        consume_event("full");
        repeat (15) @(negedge clk);
        checks++;
        if (wr_log.size() != n + 2 || wr_log[n] !== 32'h71 || wr_log[n+1] !== 32'h61) begin
            errors++;
            $display("FAIL full_resume: writes=%0d first=%h second=%h, required 2 writes 00000071 then 00000061",
                     wr_log.size() - n, (wr_log.size() > n) ? wr_log[n] : 32'hx,
                     (wr_log.size() > n + 1) ? wr_log[n+1] : 32'hx);
        end
        in_port = 7'h00;
        for (int i = 0; i < 4; i++) consume_event("full_drain");
        repeat (15) @(negedge clk);
        checks++;
        if (wr_log[wr_log.size()-1] !== 32'h7F || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_restore: last write=%h v=%0b, required 0000007f v=0", wr_log[wr_log.size()-1], evt_valid);
        end
    endtask

    task automatic test_spurious();
        int n;
        n = wr_log.size();
        in_port = 7'b0100000;
        @(negedge clk);
        in_port = 7'h00;
        repeat (10) @(negedge clk);
        checks++;
        if (wr_log.size() != n || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious: writes=%0d v=%0b, required 0 writes v=0", wr_log.size() - n, evt_valid);
        end
        exp_q.push_back(5);
        in_port = 7'b0100000;
        repeat (6) @(negedge clk);
        in_port = 7'h00;
        consume_event("spur_follow");
        checks++;
        if (wr_log.size() <= n || wr_log[n] !== 32'h5F) begin
            errors++;
            $display("FAIL spur_follow_mask: first write=%h, required 0000005f",
                     (wr_log.size() > n) ? wr_log[n] : 32'hx);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        in_port = 7'b0000010;
        repeat (4) @(negedge clk);
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h7D) begin
            errors++;
            $display("FAIL midrst_maskwr: cs=%0b data=%h, required cs=1 data=0000007d", pio_chipselect, pio_writedata);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_address !== 2'd0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop: cs=%0b wn=%0b addr=%0d v=%0b, required 0,1,0,0",
                     pio_chipselect, pio_write_n, pio_address, evt_valid);
        end
        in_port = 7'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pio_chipselect !== 1'b1 || pio_address !== 2'd2 || pio_writedata !== 32'h7F) begin
            errors++;
            $display("FAIL midrst_init: cs=%0b addr=%0d data=%h, required 1,2,0000007f",
                     pio_chipselect, pio_address, pio_writedata);
        end
        @(negedge clk);
        checks++;
        if (pio_chipselect !== 1'b0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: cs=%0b v=%0b, required 0,0", pio_chipselect, evt_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cs_prev   = 1'b0;
        reset_n   = 1'b0;
        evt_ready = 1'b0;
        in_port   = 7'h00;
        test_reset();
        test_single_line();
        test_round_robin();
        test_fifo_full();
        test_spurious();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
